// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a registered result and a 2-entry skid buffer on valid/ready.
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // Payload layout, LSB first: result, tag, zero, illegal, [ovf]
`ifdef ALU_OVERFLOW_EN
  localparam int PW = WIDTH + TAG_W + 3;
`else
  localparam int PW = WIDTH + TAG_W + 2;
`endif

  state_t           state_r;
  logic [PW-1:0]    main_r;
  logic [PW-1:0]    skid_r;
  logic [PW-1:0]    new_s;
  logic [CNT_W-1:0] op_count_r;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             illegal_s;
  logic             zero_s;
  logic             accept_s;
  logic             xfer_s;

  assign in_ready  = (state_r != ST_FULL);
  assign out_valid = (state_r != ST_EMPTY);
  assign accept_s  = in_valid && in_ready;
  assign xfer_s    = out_valid && out_ready;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // Operation decode and result computation
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    illegal_s = 1'b0;
    case (op)
      4'b0000: alu_res_s = a & b;
      4'b0001: alu_res_s = a | b;
      4'b0010: alu_res_s = sum_s;
      4'b0110: alu_res_s = diff_s;
      4'b0111: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: alu_res_s = ~(a | b);
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  assign zero_s = (alu_res_s == {WIDTH{1'b0}});

`ifdef ALU_OVERFLOW_EN
  logic ovf_s;

  // Signed overflow detection for ADD and SUB only
  always_comb begin
    ovf_s = 1'b0;
    if (op == 4'b0010) begin
      ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    end else if (op == 4'b0110) begin
      ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ovf_s = 1'b0;
    end
  end

  assign new_s = {ovf_s, illegal_s, zero_s, in_tag, alu_res_s};
  assign ovf   = main_r[PW-1];
`else
  assign new_s = {illegal_s, zero_s, in_tag, alu_res_s};
  assign ovf   = 1'b0;
`endif

  assign result     = main_r[WIDTH-1:0];
  assign out_tag    = main_r[WIDTH+TAG_W-1:WIDTH];
  assign zero       = main_r[WIDTH+TAG_W];
  assign illegal_op = main_r[WIDTH+TAG_W+1];
  assign op_count   = op_count_r;

  // Skid-buffer FSM: main feeds the outputs, skid catches one op while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      main_r  <= {PW{1'b0}};
      skid_r  <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_r  <= new_s;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept_s && xfer_s) begin
            main_r <= new_s;
          end else if (accept_s) begin
            skid_r  <= new_s;
            state_r <= ST_FULL;
          end else if (xfer_s) begin
            state_r <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer_s) begin
            main_r  <= skid_r;
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of accepted operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && (op_count_r != {CNT_W{1'b1}})) begin
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed steps plus randomized traffic
// compared against a FIFO-of-expected-results reference model.
module tb_ex_alu_stage;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  logic [4:0]  out_tag;
  logic        ovf;
  logic [15:0] op_count;

  ex_alu_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .illegal_op(illegal_op), .out_tag(out_tag), .ovf(ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic        ovf;
    logic [4:0]  tag;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  seen[$];
  int          tests = 0;
  int          failed = 0;
  int          cnt = 0;
  int          xfers = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [4:0] t);
    exp_t   e;
    longint sx;
    longint sy;
    longint r;
    e = '0;
    e.tag = t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 64'sd0;
    case (o)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2:  begin r = sx + sy; e.res = r[31:0];
                   e.ovf = OVF_EN && (r > 64'sd2147483647 || r < -64'sd2147483648); end
      4'd6:  begin r = sx - sy; e.res = r[31:0];
                   e.ovf = OVF_EN && (r > 64'sd2147483647 || r < -64'sd2147483648); end
      4'd7:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: e.res = ~(x | y);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Called just after a falling edge with inputs already driven; advances one cycle.
  task automatic step();
    exp_t h;
    bit   was_full;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (out_valid && q.size() != 0) begin
      h = q[0];
      chk("result", result, h.res);
      chk("zero", zero, h.zero);
      chk("illegal_op", illegal_op, h.ill);
      chk("ovf", ovf, h.ovf);
      chk("out_tag", out_tag, h.tag);
    end
    was_full = (q.size() == 2);
    if (out_ready && q.size() != 0) begin
      seen.push_back(q[0].tag);
      void'(q.pop_front());
      xfers++;
    end
    if (in_valid && !was_full) begin
      q.push_back(model(op, a, b, in_tag));
      if (cnt != 65535) cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("op_count", op_count, cnt);
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t);
    in_valid = 1'b1; op = o; a = x; b = y; in_tag = t;
  endtask

  logic [3:0] legal_ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  logic [3:0] bad_ops [10] = '{4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_tag", out_tag, 5'd0);
    chk("rst_count", op_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD
    out_ready = 1'b1;
    drive(4'b0010, 32'd5, 32'd7, 5'd9);
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_result", result, 32'd12);
    chk("single_zero", zero, 1'b0);
    chk("single_count", op_count, 16'd1);
    step();
    chk("single_drained", out_valid, 1'b0);

    // Operation sweep with literal expectations
    drive(4'b0110, 32'd3, 32'd3, 5'd1); step(); in_valid = 1'b0;
    chk("sub_res", result, 32'd0); chk("sub_zero", zero, 1'b1); step();
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd2); step(); in_valid = 1'b0;
    chk("slt_res", result, 32'd1); step();
    drive(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd3); step(); in_valid = 1'b0;
    chk("and_res", result, 32'h0000_00F0); step();
    drive(4'b1100, 32'd0, 32'd0, 5'd4); step(); in_valid = 1'b0;
    chk("nor_res", result, 32'hFFFF_FFFF); step();
    drive(4'b1111, 32'd8, 32'd9, 5'd5); step(); in_valid = 1'b0;
    chk("ill_res", result, 32'd0); chk("ill_flag", illegal_op, 1'b1); step();

    // Overflow cases
    drive(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd6); step(); in_valid = 1'b0;
    chk("ovf_add_res", result, 32'h8000_0000); chk("ovf_add", ovf, OVF_EN); step();
    drive(4'b0110, 32'h8000_0000, 32'd1, 5'd7); step(); in_valid = 1'b0;
    chk("ovf_sub_res", result, 32'h7FFF_FFFF); chk("ovf_sub", ovf, OVF_EN); step();

    // Backpressure: three ADDs, only two fit
    seen.delete();
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd1); step();
    drive(4'b0010, 32'd2, 32'd2, 5'd2); step();
    chk("bp_full", in_ready, 1'b0);
    drive(4'b0010, 32'd3, 32'd3, 5'd3); step();
    chk("bp_held", in_ready, 1'b0);
    chk("bp_stable_tag", out_tag, 5'd1);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 5'd1);
      chk("bp_order1", seen[1], 5'd2);
      chk("bp_order2", seen[2], 5'd3);
    end

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(4'b0001, 32'h10, 32'h01, 5'd10); step();
    drive(4'b0001, 32'h20, 32'h02, 5'd11); step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_count", op_count, 16'd0);
    chk("mid_rst_result", result, 32'd0);
    q.delete();
    cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    step();
    step();

    // Full throughput
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      drive(legal_ops[$urandom_range(0, 5)], rnd_operand(), rnd_operand(), 5'(i));
      step();
      chk("tput_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("tput_xfers", xfers, 10);
    chk("tput_count", op_count, 16'd10);

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 9)]
                                         : legal_ops[$urandom_range(0, 5)];
      a = rnd_operand();
      b = rnd_operand();
      in_tag = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
